// File: rtl/palindrome_arbiter_ctrl.sv
// Shared palindrome-check engine: round-robin grant of NUM_REQ requesters, digit-serial
// decimal reversal, tagged result over a valid/ready port, saturating palindrome counter.
module palindrome_arbiter_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*WIDTH-1:0] in_number,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ID_W-1:0]          res_id,
  output logic [WIDTH-1:0]         res_number,
  output logic                     res_is_palindrome,
  output logic                     busy,
  output logic [CNT_W-1:0]         pal_count
);

  // Four spare bits hold any reversal without truncation (e.g. 255 -> 552).
  localparam int REV_W = WIDTH + 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_r;
  logic [ID_W-1:0]    ptr_r;
  logic [WIDTH-1:0]   temp_r;
  logic [REV_W-1:0]   rev_r;
  logic [WIDTH-1:0]   orig_r;
  logic [ID_W-1:0]    id_r;
  logic               res_valid_r;
  logic [ID_W-1:0]    res_id_r;
  logic [WIDTH-1:0]   res_number_r;
  logic               res_pal_r;
  logic               busy_r;
  logic [CNT_W-1:0]   pal_count_r;

  logic               found_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [WIDTH-1:0]   grant_num_s;
  logic [WIDTH-1:0]   digit_s;
  logic [WIDTH-1:0]   temp_div_s;
  logic [REV_W-1:0]   rev_next_s;
  logic               is_pal_s;

  // Round-robin search: first valid requester after the pointer, wrapping.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found_s && in_valid[(int'(ptr_r) + k) % NUM_REQ]) begin
        found_s     = 1'b1;
        grant_idx_s = ID_W'((int'(ptr_r) + k) % NUM_REQ);
      end else begin
        found_s     = found_s;
      end
    end
  end

  // One-hot grant, only offered while idle.
  always_comb begin
    grant_s = '0;
    if ((state_r == IDLE) && found_s) begin
      grant_s = NUM_REQ'(1'b1) << grant_idx_s;
    end else begin
      grant_s = '0;
    end
  end

  assign grant_num_s = in_number[int'(grant_idx_s) * WIDTH +: WIDTH];
  assign digit_s     = temp_r % WIDTH'(4'd10);
  assign temp_div_s  = temp_r / WIDTH'(4'd10);
  assign rev_next_s  = (rev_r * REV_W'(4'd10)) + REV_W'(digit_s);
  assign is_pal_s    = ({4'b0000, orig_r} == rev_r);

  // Control FSM, digit-serial datapath, result registers and hit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ptr_r        <= ID_W'(NUM_REQ - 1);
      temp_r       <= '0;
      rev_r        <= '0;
      orig_r       <= '0;
      id_r         <= '0;
      res_valid_r  <= 1'b0;
      res_id_r     <= '0;
      res_number_r <= '0;
      res_pal_r    <= 1'b0;
      busy_r       <= 1'b0;
      pal_count_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            orig_r  <= grant_num_s;
            temp_r  <= grant_num_s;
            rev_r   <= '0;
            id_r    <= grant_idx_s;
            ptr_r   <= grant_idx_s;
            busy_r  <= 1'b1;
            state_r <= ITER;
          end else begin
            state_r <= IDLE;
          end
        end
        ITER: begin
          if (temp_r != '0) begin
            rev_r  <= rev_next_s;
            temp_r <= temp_div_s;
          end else begin
            res_pal_r    <= is_pal_s;
            res_number_r <= orig_r;
            res_id_r     <= id_r;
            res_valid_r  <= 1'b1;
            state_r      <= DONE;
          end
        end
        DONE: begin
          if (res_valid_r && res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
            if (res_pal_r && (pal_count_r != {CNT_W{1'b1}})) begin
              pal_count_r <= pal_count_r + CNT_W'(1'b1);
            end else begin
              pal_count_r <= pal_count_r;
            end
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready          = grant_s;
  assign res_valid         = res_valid_r;
  assign res_id            = res_id_r;
  assign res_number        = res_number_r;
  assign res_is_palindrome = res_pal_r;
  assign busy              = busy_r;
  assign pal_count         = pal_count_r;

endmodule

// File: tb/tb_palindrome_arbiter_ctrl.sv
// Directed bench: a table of single requests, then backpressure, mid-operation reset and
// round-robin sequences. A CNT_W=2 copy shares the stimulus to exercise counter saturation.
module tb_palindrome_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  in_valid;
  logic [31:0] in_number;
  logic        res_ready;
  logic [3:0]  in_ready, in_ready2;
  logic        res_valid, res_valid2;
  logic [1:0]  res_id, res_id2;
  logic [7:0]  res_number, res_number2;
  logic        res_pal, res_pal2;
  logic        busy, busy2;
  logic [15:0] pal_count;
  logic [1:0]  pal_count2;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int exp_cnt2 = 0;

  typedef struct {
    int         req;
    logic [7:0] num;
    logic       pal;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  palindrome_arbiter_ctrl #(.NUM_REQ(4), .WIDTH(8), .ID_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_number(in_number),
    .in_ready(in_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_number(res_number), .res_is_palindrome(res_pal),
    .busy(busy), .pal_count(pal_count));

  palindrome_arbiter_ctrl #(.NUM_REQ(4), .WIDTH(8), .ID_W(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_number(in_number),
    .in_ready(in_ready2), .res_valid(res_valid2), .res_ready(res_ready),
    .res_id(res_id2), .res_number(res_number2), .res_is_palindrome(res_pal2),
    .busy(busy2), .pal_count(pal_count2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic bump(input logic p);
    exp_cnt = exp_cnt + int'(p);
    if (exp_cnt2 < 3) exp_cnt2 = exp_cnt2 + int'(p);
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Single isolated request; caller sits 1 time unit after a rising edge, state IDLE.
  task automatic send(input int req, input logic [7:0] num, input logic pal, input int lat_exp);
    int lat;
    logic [3:0] onehot;
    onehot = 4'b0001 << req;
    res_ready = 1'b1;
    in_valid = onehot;
    in_number[req*8 +: 8] = num;
    #1;
    chk("grant", 32'(in_ready), 32'(onehot));
    @(posedge clk); #1;
    chk("grant_one_cycle", 32'(in_ready), 32'd0);
    in_valid = 4'b0000;
    wait_res(lat);
    chk("latency", 32'(lat), 32'(lat_exp));
    chk("res_id", 32'(res_id), 32'(req));
    chk("res_number", 32'(res_number), 32'(num));
    chk("verdict", 32'(res_pal), 32'(pal));
    chk("busy_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    bump(pal);
    chk("res_cleared", 32'(res_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("pal_count", 32'(pal_count), 32'(exp_cnt));
    chk("pal_count_sat", 32'(pal_count2), 32'(exp_cnt2));
  endtask

  initial begin
    int lat;
    logic seen;
    logic rr_pal[4];

    vecs[0] = '{0, 8'd121, 1'b1, 4};
    vecs[1] = '{1, 8'd255, 1'b0, 4};
    vecs[2] = '{2, 8'd252, 1'b1, 4};
    vecs[3] = '{3, 8'd0,   1'b1, 1};
    vecs[4] = '{0, 8'd10,  1'b0, 3};
    vecs[5] = '{1, 8'd7,   1'b1, 2};
    vecs[6] = '{2, 8'd200, 1'b0, 4};
    vecs[7] = '{3, 8'd100, 1'b0, 4};
    vecs[8] = '{0, 8'd9,   1'b1, 2};
    rr_pal = '{1'b1, 1'b0, 1'b1, 1'b1};

    in_valid  = 4'b1111;
    in_number = {8'd44, 8'd33, 8'd12, 8'd11};
    res_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pal_count", 32'(pal_count), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_number", 32'(res_number), 32'd0);
    chk("rst_verdict", 32'(res_pal), 32'd0);
    chk("rst_priority", 32'(in_ready), 32'd1);
    in_valid = 4'b0000;
    #1;
    chk("rst_no_grant", 32'(in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].req, vecs[i].num, vecs[i].pal, vecs[i].lat);
    end

    // Backpressure: result held while consumer stalls, no grant to waiting req1.
    res_ready = 1'b0;
    in_valid = 4'b0100;
    in_number[23:16] = 8'd131;
    #1;
    chk("bp_grant", 32'(in_ready), 32'b0100);
    @(posedge clk); #1;
    in_valid = 4'b0010;
    wait_res(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", 32'({res_valid, res_id, res_number, res_pal, busy, in_ready}),
          32'({1'b1, 2'd2, 8'd131, 1'b1, 1'b1, 4'b0000}));
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    bump(1'b1);
    chk("bp_release_valid", 32'(res_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(in_ready), 32'b0010);
    chk("bp_pal_count", 32'(pal_count), 32'(exp_cnt));
    in_valid = 4'b0000;

    // Reset while iterating on 131.
    in_valid = 4'b0010;
    in_number[15:8] = 8'd131;
    @(posedge clk); #1;
    in_valid = 4'b0000;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    exp_cnt2 = 0;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(pal_count), 32'd0);
    chk("mid_rst_count_sat", 32'(pal_count2), 32'd0);
    chk("mid_rst_outs", 32'({res_id, res_number, res_pal}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);

    // Round robin with all four requesters continuously valid.
    in_number = {8'd44, 8'd33, 8'd12, 8'd11};
    in_valid = 4'b1111;
    res_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", 32'(in_ready), 32'(4'b0001 << (g % 4)));
      @(posedge clk); #1;
      wait_res(lat);
      chk("rr_latency", 32'(lat), 32'd3);
      chk("rr_id", 32'(res_id), 32'(g % 4));
      chk("rr_verdict", 32'(res_pal), 32'(rr_pal[g % 4]));
      @(posedge clk); #1;
      bump(rr_pal[g % 4]);
      chk("rr_pal_count", 32'(pal_count), 32'(exp_cnt));
      chk("rr_pal_count_sat", 32'(pal_count2), 32'(exp_cnt2));
    end
    in_valid = 4'b0000;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/palindrome_arbiter_ctrl.md
Name: palindrome_arbiter_ctrl

Overview:
Shared, sequenced palindrome-check engine serving NUM_REQ requesters. A round-robin arbiter grants one requester's number. An iterative datapath then reverses the number's decimal digits, one digit per clock. The block returns the palindrome verdict, tagged with the requester ID, over a valid/ready result port. It replaces per-requester combinational checkers where area matters, and keeps a saturating count of palindromes found.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, bit width of each requester's unsigned number
ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ))
CNT_W, 16, width of palindrome hit counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  NUM_REQ  per-requester request valid
in_number  input  NUM_REQ*WIDTH  packed numbers; requester i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  NUM_REQ  one-hot grant/accept; at most one bit high
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_id  output  ID_W  requester index the result belongs to
res_number  output  WIDTH  number that was checked
res_is_palindrome  output  1  1 if number equals its decimal reversal
busy  output  1  high in ITER or DONE
pal_count  output  CNT_W  count of palindromes delivered, saturating

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: state=IDLE; res_valid=0, res_id=0, res_number=0, res_is_palindrome=0, busy=0, pal_count=0; RR pointer=NUM_REQ-1, so requester 0 has first priority.
- Registers: temp (WIDTH), rev (WIDTH+4, wide enough for any reversal, e.g. 255->552), orig (WIDTH), id (ID_W).
- No truncation in rev; the compare orig==rev is done at full WIDTH+4 width.
- State IDLE:
  - in_ready is combinational: the one-hot bit of the first requester with in_valid=1, searching from pointer+1 upward with wrap.
  - in_ready is all-zero if no in_valid is high, and all-zero in every other state.
  - On a handshake edge: orig=temp=granted number, rev=0, id=granted index, pointer=granted index; go to ITER.
- State ITER, each edge:
  - If temp!=0: rev=rev*10+temp%10, temp=temp/10; stay in ITER.
  - If temp==0: res_is_palindrome=(orig==rev), res_number=orig, res_id=id, res_valid=1; go to DONE.
- State DONE:
  - Hold all res_* outputs stable while res_ready=0.
  - On an edge with res_valid&&res_ready: res_valid=0, go to IDLE, pal_count+=res_is_palindrome, saturating at all-ones.
  - No new grant is issued in the same cycle; the next grant is possible from the following cycle.
- Latency: a D-digit number gives res_valid high D+1 edges after the accept edge. The value 0 has D=0, so latency is 1 edge, and 0 is a palindrome.
- Requesters must hold in_valid and in_number stable until in_ready. Deasserting in_valid before grant is legal; that requester simply loses arbitration.
- Fairness: a requester that keeps in_valid asserted is served within NUM_REQ grants.
- Reset mid-operation (ITER or DONE): immediate return to reset values. The pending result is discarded; no res_valid pulse is emitted.
- Single-digit numbers (1..9) are palindromes. Trailing-zero numbers (10, 100, 200) are not, since their reversal drops leading zeros.

Test Plan:
- Single request, req0 number=121, res_ready=1: in_ready=0001 for 1 cycle; res_valid 4 edges later with res_id=0, res_is_palindrome=1; pal_count=1 after handshake.
- Truncation check: number=255 -> res_is_palindrome=0 (rev=552); number=252 -> 1; number=0 -> 1 after 1 edge; number=10 -> 0; number=7 -> 1 after 2 edges.
- All 4 requesters valid continuously with distinct numbers 11, 12, 33, 44: grant order 0,1,2,3,0; ids match; verdicts 1,0,1,1; pal_count increments by 3 per round.
- Backpressure: hold res_ready=0 for 5 cycles in DONE: res_* outputs stable, in_ready=0, busy=1; release -> one handshake, state IDLE next cycle.
- Assert rst_n=0 mid-ITER while checking 131: all outputs return to reset values asynchronously, no res_valid afterward; after release, req0 has first priority.
- Saturation: preset via CNT_W=2 build, deliver 5 palindromes -> pal_count stays 3.
